// File: rtl/decoder_scan_sequencer.sv
// Registered select/enable sequencer driving a 3x8 decoder: free-run, stop and single-step scanning.
// Optional break-before-make blanking cycle on each advance when SCAN_BLANKING_EN is defined.
module decoder_scan_sequencer #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic step,
  input  logic dir,
  output logic a,
  output logic b,
  output logic c,
  output logic en,
  output logic busy,
  output logic wrap
);

  localparam int unsigned PC_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(DIV - 1);

`ifdef SCAN_BLANKING_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BLANK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [PC_W-1:0]   pc;
  logic [IDX_W-1:0]  idx_next_c;
  logic              wrap_next_c;

  // Neighbouring index in the current direction and whether moving there wraps
  always_comb begin
    idx_next_c  = dir ? idx - IDX_W'(1) : idx + IDX_W'(1);
    wrap_next_c = dir ? (idx == IDX_W'(0)) : (idx == IDX_W'(7));
  end

  assign {a, b, c} = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      pc    <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            pc    <= '0;
            en    <= 1'b1;
            busy  <= 1'b1;
          end else if (step) begin
            idx  <= idx_next_c;
            wrap <= wrap_next_c;
          end
        end
        S_RUN: begin
          // stop outranks an advance landing in the same cycle
          if (stop) begin
            state <= S_IDLE;
            pc    <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
          end else if (pc == PC_LAST) begin
            pc   <= '0;
            idx  <= idx_next_c;
            wrap <= wrap_next_c;
`ifdef SCAN_BLANKING_EN
            state <= S_BLANK;
            en    <= 1'b0;
`endif
          end else begin
            pc <= pc + PC_W'(1);
          end
        end
`ifdef SCAN_BLANKING_EN
        S_BLANK: begin
          pc <= '0;
          if (stop) begin
            state <= S_IDLE;
            en    <= 1'b0;
            busy  <= 1'b0;
          end else begin
            state <= S_RUN;
            en    <= 1'b1;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          pc    <= '0;
          en    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench for decoder_scan_sequencer (DIV=4): slot-count model checked every cycle
// plus hand-computed expectations for reset, up/down scan, stop/start and single-step.
module tb_decoder_scan_sequencer;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst, start, stop, step, dir;
  logic a, b, c, en, busy, wrap;

  int errors = 0;
  int checks = 0;

  decoder_scan_sequencer #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .dir(dir),
    .a(a), .b(b), .c(c), .en(en), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Model: running flag, index, and how many enabled cycles the current index has been shown
  bit m_valid = 0;
  bit m_run = 0;
  bit m_blank = 0;
  int m_idx = 0;
  int m_held = 0;
  bit m_wrap = 0;

  function automatic void m_advance(input logic d);
    if (!d) begin
      m_idx  = (m_idx + 1) % 8;
      m_wrap = (m_idx == 0);
    end else begin
      m_idx  = (m_idx + 7) % 8;
      m_wrap = (m_idx == 7);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_run = 0; m_blank = 0; m_idx = 0; m_held = 0; m_wrap = 0;
    end else if (m_valid) begin
      m_wrap = 0;
      if (!m_run) begin
        if (start) begin
          m_run = 1;
          m_held = 1;
        end else if (step) begin
          m_advance(dir);
        end
      end else if (stop) begin
        m_run = 0;
        m_blank = 0;
      end else if (m_blank) begin
        m_blank = 0;
        m_held = 1;
      end else if (m_held == DIV) begin
        m_advance(dir);
`ifdef SCAN_BLANKING_EN
        m_blank = 1;
`else
        m_held = 1;
`endif
      end else begin
        m_held++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      logic [5:0] got, exp;
      got = {a, b, c, en, busy, wrap};
      exp = {3'(m_idx), m_run && !m_blank, m_run, m_wrap};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cycle t=%0t abc_en_busy_wrap got=%b exp=%b", $time, got, exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic lit(input string name, input logic [2:0] e_idx, input logic e_en,
                     input logic e_busy, input logic e_wrap);
    logic [5:0] got, exp;
    got = {a, b, c, en, busy, wrap};
    exp = {e_idx, e_en, e_busy, e_wrap};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t abc_en_busy_wrap got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  initial begin
    rst = 1; start = 1; stop = 0; step = 0; dir = 0;
    tick(2);
    lit("reset", 3'd0, 0, 0, 0);
    rst = 0; start = 1;
    tick(1);
    start = 0;
    lit("start_idx0", 3'd0, 1, 1, 0);

    // Up-scan: slot boundaries and the wrap 32 cycles after start
    tick(3);
    lit("slot0_last", 3'd0, 1, 1, 0);
    tick(1);
    lit("slot1_first", 3'd1, 1, 1, 0);
    tick(28);
    lit("up_wrap", 3'd0, 1, 1, 1);
    tick(1);
    lit("up_wrap_end", 3'd0, 1, 1, 0);

    // Stop during index 5, restart, then simultaneous start+stop
    tick(20);
    lit("at_idx5", 3'd5, 1, 1, 0);
    stop = 1;
    tick(1);
    stop = 0;
    lit("stop_hold5", 3'd5, 0, 0, 0);
    start = 1;
    tick(1);
    start = 0;
    lit("resume5", 3'd5, 1, 1, 0);
    tick(1);
    start = 1; stop = 1;
    tick(1);
    start = 0; stop = 0;
    lit("start_stop_idle", 3'd5, 0, 0, 0);

    // Single-step in IDLE, including the 7->0 wrap
    step = 1;
    tick(2);
    step = 0;
    tick(1);
    lit("step_to7", 3'd7, 0, 0, 0);
    step = 1;
    tick(1);
    step = 0;
    lit("step_wrap", 3'd0, 0, 0, 1);
    tick(1);
    lit("step_wrap_end", 3'd0, 0, 0, 0);

    // start wins over step; step while running adds nothing
    start = 1; step = 1;
    tick(1);
    start = 0;
    lit("start_over_step", 3'd0, 1, 1, 0);
    tick(3);
    step = 0;
    lit("run_step_ignored", 3'd0, 1, 1, 0);
    tick(1);
    lit("run_step_adv", 3'd1, 1, 1, 0);
    stop = 1;
    tick(1);
    stop = 0;

    // Reset, then step down to index 3
    rst = 1;
    tick(1);
    rst = 0;
    lit("rst_idle", 3'd0, 0, 0, 0);
    dir = 1; step = 1;
    tick(5);
    step = 0;
    lit("down_step3", 3'd3, 0, 0, 0);

    // Down-scan 3,2,1,0,7 then dir flip mid-slot of 7 gives 0
    start = 1;
    tick(1);
    start = 0;
    lit("down_start3", 3'd3, 1, 1, 0);
    tick(16);
    lit("down_wrap7", 3'd7, 1, 1, 1);
    tick(1);
    dir = 0;
    tick(3);
    lit("dir_flip_to0", 3'd0, 1, 1, 1);

    // Reset mid-scan
    rst = 1;
    tick(1);
    rst = 0;
    lit("rst_midscan", 3'd0, 0, 0, 0);

    // Free run with periodic direction changes
    start = 1;
    tick(1);
    start = 0;
    for (int i = 0; i < 6; i++) begin
      tick(7);
      dir = ~dir;
    end
    stop = 1;
    tick(1);
    stop = 0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
